frame_windower: RTL and testbench
=================================

# frame_windower

Front-end framing stage of the MEL pipeline, directly upstream of the ping-pong bit-reverse buffer. Accepts a continuous stream of signed audio samples and keeps a history of recent samples. Each time a frame is due, it emits a burst of FRAME_LEN consecutive windowed samples, oldest first, one per cycle. Its data_out/data_valid pair drives the bit-reverse buffer's data_in/data_valid directly, so every burst fills exactly one buffer half.

## Interface
- WIDTH, 8: sample width, two's complement, in and out
- FRAME_LEN, 128: samples per frame; power of two; equals the downstream buffer DEPTH
- HOP, 64: new samples between frame starts; 1 ≤ HOP ≤ FRAME_LEN
- COEF_WIDTH, 8: window coefficient width, unsigned, Q0.COEF_WIDTH
- clk  in  1  system clock; all logic on posedge
- rst_n  in  1  asynchronous, active-low reset
- sample_in  in  WIDTH  input sample
- sample_valid  in  1  sample_in is accepted this cycle; no backpressure
- coef_we  in  1  window coefficient write strobe
- coef_addr  in  $clog2(FRAME_LEN)  coefficient index
- coef_data  in  COEF_WIDTH  coefficient value
- overrun_clr  in  1  clears overrun
- data_out  out  WIDTH  windowed sample
- data_valid  out  1  data_out is valid
- frame_start  out  1  high with the first sample of each frame
- overrun  out  1  sticky: a due frame was dropped

## Operation
- History RAM: 2*FRAME_LEN entries, write pointer wr_ptr wraps modulo 2*FRAME_LEN. Each accepted sample is written at wr_ptr, then wr_ptr increments. History RAM is not reset.
- Coefficient RAM: FRAME_LEN × COEF_WIDTH, written by coef_we, not reset. Software loads it before the first frame. A write during emission affects every read issued after the write cycle.
- Sample counter: the first frame is due on the accepted sample that brings the count since reset to FRAME_LEN. Each later frame is due every HOP accepted samples after that.
- Frame due: base = wr_ptr_after_write − FRAME_LEN (mod 2*FRAME_LEN). The frame covers the FRAME_LEN most recent samples, including the triggering one.
- FSM states:
  - IDLE to EMIT on a due frame.
  - EMIT issues reads base+k, k = 0..FRAME_LEN−1, one per cycle, and applies w[k] to sample k.
  - At the end of EMIT: go to EMIT with the pending base if pending is set (clearing pending), otherwise go to IDLE.
- Pending: one-deep slot holding a base.
  - A frame due during EMIT is stored in pending if the slot is empty.
  - If the slot is already full, the frame is dropped and overrun is set.
  - A due frame in the cycle EMIT finishes is taken as pending; back-to-back frames have no gap.
- Arithmetic: p = sample × {1'b0, coef}, signed, WIDTH+COEF_WIDTH+1 bits. data_out = p >>> COEF_WIDTH, which is floor (truncation toward −inf). No saturation is needed.
- overrun: set on a drop, cleared by overrun_clr. If both happen in the same cycle, set wins.

## Timing
- Reset values: data_out = 0, data_valid = 0, frame_start = 0, overrun = 0. Also reset: wr_ptr = 0, sample count = 0, pending empty, FSM in IDLE.
- Latency: 2 cycles (RAM read register, then multiply/output register).
  - If the due sample is accepted at cycle t, sample k of the frame appears at cycle t+2+k.
  - data_valid stays high for exactly FRAME_LEN consecutive cycles per frame.
- Reading a pending frame: reads must never return data overwritten after its trigger. The 2*FRAME_LEN history depth guarantees this at one sample per cycle.
- Reset asserted mid-frame: outputs go low immediately. The burst is abandoned, and after release framing restarts from a count of zero.
- Writing and reading the same history address in one cycle never occurs by construction.

## Test plan
For all scenarios: FRAME_LEN=8, HOP=4, WIDTH=8, COEF_WIDTH=8.
- All coefficients 255, samples 0..7 → one burst, data_out = 0,0,1,2,3,4,5,6. frame_start on the first sample; data_valid high for 8 cycles, starting 2 cycles after sample 7.
- Then samples 8..11 at a slow rate → second burst over samples 4..11 (out 3,4,5,6,7,8,9,10). No burst occurs before sample 11.
- Coefficient w[k] = 32k, samples −128 and −1 at k=7 → −128×224>>>8 = −112, −1×224>>>8 = −1.
- Samples every cycle from reset:
  - Frame A is due at sample 8 and emits.
  - The frame due at sample 12 goes to pending and follows A with no gap.
  - The frame due at sample 16 is dropped and overrun = 1.
  - overrun_clr returns overrun to 0.
- Assert rst_n low at the 4th cycle of a burst → data_valid = 0 and data_out = 0 at once. After release, the next burst needs 8 new samples.

Source files
------------

// File: rtl/frame_windower.sv
// Sliding-window framer: keeps a 2*FRAME_LEN sample history and emits FRAME_LEN
// windowed samples (oldest first) every HOP accepted samples, with a one-deep pending slot.
module frame_windower #(
    parameter int WIDTH      = 8,
    parameter int FRAME_LEN  = 128,
    parameter int HOP        = 64,
    parameter int COEF_WIDTH = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [WIDTH-1:0]             sample_in,
    input  logic                         sample_valid,
    input  logic                         coef_we,
    input  logic [$clog2(FRAME_LEN)-1:0] coef_addr,
    input  logic [COEF_WIDTH-1:0]        coef_data,
    input  logic                         overrun_clr,
    output logic [WIDTH-1:0]             data_out,
    output logic                         data_valid,
    output logic                         frame_start,
    output logic                         overrun
);

    localparam int AW  = $clog2(FRAME_LEN);
    localparam int HAW = AW + 1;
    localparam int PW  = WIDTH + COEF_WIDTH + 1;

    localparam logic [AW-1:0]  FRAME_LAST = AW'(FRAME_LEN - 1);
    localparam logic [AW-1:0]  HOP_LAST   = AW'(HOP - 1);
    localparam logic [HAW-1:0] BASE_OFF   = HAW'(FRAME_LEN - 1);

    typedef enum logic {IDLE, EMIT} state_t;

    state_t state;

    logic [WIDTH-1:0]      hist [2*FRAME_LEN];
    logic [COEF_WIDTH-1:0] coef [FRAME_LEN];
    logic [WIDTH-1:0]      hist_q;
    logic [COEF_WIDTH-1:0] coef_q;

    logic [HAW-1:0] wr_ptr;
    logic [HAW-1:0] base;
    logic [HAW-1:0] pend_base;
    logic [HAW-1:0] due_base;
    logic [HAW-1:0] rd_addr;
    logic [AW-1:0]  k;
    logic [AW-1:0]  cnt;
    logic           primed;
    logic           pend_valid;
    logic           due;
    logic           last;
    logic           rd_en;
    logic           drop;
    logic           rd_valid;
    logic           rd_first;

    logic signed [PW-1:0] prod;

    // Base is wr_ptr+1-FRAME_LEN: the triggering sample is written this same cycle.
    always_comb begin
        due      = sample_valid && (primed ? (cnt == HOP_LAST) : (cnt == FRAME_LAST));
        due_base = wr_ptr - BASE_OFF;
        rd_en    = (state == EMIT);
        last     = rd_en && (k == FRAME_LAST);
        rd_addr  = base + HAW'(k);
        drop     = due && rd_en && pend_valid;
        prod     = PW'($signed(hist_q)) * PW'($signed({1'b0, coef_q}));
    end

    always_ff @(posedge clk) begin
        if (sample_valid) hist[wr_ptr] <= sample_in;
        if (coef_we)      coef[coef_addr] <= coef_data;
        if (rd_en) begin
            hist_q <= hist[rd_addr];
            coef_q <= coef[k];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            wr_ptr      <= '0;
            cnt         <= '0;
            primed      <= 1'b0;
            k           <= '0;
            base        <= '0;
            pend_base   <= '0;
            pend_valid  <= 1'b0;
            rd_valid    <= 1'b0;
            rd_first    <= 1'b0;
            data_out    <= '0;
            data_valid  <= 1'b0;
            frame_start <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            if (sample_valid) begin
                wr_ptr <= wr_ptr + 1'b1;
                if (due) begin
                    cnt    <= '0;
                    primed <= 1'b1;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end

            rd_valid    <= rd_en;
            rd_first    <= rd_en && (k == '0);
            data_valid  <= rd_valid;
            frame_start <= rd_first;
            if (rd_valid) data_out <= WIDTH'(prod >>> COEF_WIDTH);

            if (overrun_clr) overrun <= 1'b0;
            if (drop)        overrun <= 1'b1;

            case (state)
                IDLE: begin
                    if (due) begin
                        state <= EMIT;
                        base  <= due_base;
                        k     <= '0;
                    end
                end
                EMIT: begin
                    k <= k + 1'b1;
                    if (due && !pend_valid && !last) begin
                        pend_valid <= 1'b1;
                        pend_base  <= due_base;
                    end
                    // A full slot at the final read still counts as occupied, so a due frame then is dropped.
                    if (last) begin
                        if (pend_valid) begin
                            base       <= pend_base;
                            pend_valid <= 1'b0;
                        end else if (due) begin
                            base <= due_base;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_frame_windower.sv
// Self-checking bench for frame_windower: cycle-level reference model built from
// frame-due times, a start schedule and floor arithmetic on the kept sample list.
module tb_frame_windower;

    localparam int W   = 8;
    localparam int FL  = 8;
    localparam int HP  = 4;
    localparam int CW  = 8;
    localparam int AWT = $clog2(FL);

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [W-1:0]   sample_in = '0;
    logic           sample_valid = 1'b0;
    logic           coef_we = 1'b0;
    logic [AWT-1:0] coef_addr = '0;
    logic [CW-1:0]  coef_data = '0;
    logic           overrun_clr = 1'b0;
    logic [W-1:0]   data_out;
    logic           data_valid;
    logic           frame_start;
    logic           overrun;

    always #5 clk = ~clk;

    frame_windower #(.WIDTH(W), .FRAME_LEN(FL), .HOP(HP), .COEF_WIDTH(CW)) dut (
        .clk(clk), .rst_n(rst_n), .sample_in(sample_in), .sample_valid(sample_valid),
        .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
        .overrun_clr(overrun_clr), .data_out(data_out), .data_valid(data_valid),
        .frame_start(frame_start), .overrun(overrun)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    int smp[$];
    int starts[$];
    int exp_data[int];
    bit exp_fs[int];
    int coef_m[FL];
    bit ov_m;
    int n_acc;

    bit         exp_v;
    bit         exp_f;
    logic [W-1:0] exp_d8;

    int obs[$];

    function automatic int wfloor(input int s, input int c);
        int p;
        int q;
        p = s * c;
        q = p / 256;
        if (p < 0 && q * 256 != p) q = q - 1;
        return q;
    endfunction

    task automatic model_reset;
        smp.delete();
        starts.delete();
        exp_data.delete();
        exp_fs.delete();
        ov_m  = 1'b0;
        n_acc = 0;
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        sample_valid = 1'b0;
        coef_we = 1'b0;
        overrun_clr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    // One clock: drive inputs, advance the model at the edge, leave expectations for this cycle.
    task automatic tick(input bit v, input int s, input bit clr, input bit we, input int addr, input int data);
        bit queued;
        bit dropped;
        int last_end;
        int st;
        sample_valid = v;
        sample_in    = W'(s);
        overrun_clr  = clr;
        coef_we      = we;
        coef_addr    = AWT'(addr);
        coef_data    = CW'(data);
        @(posedge clk);
        cyc++;
        dropped = 1'b0;
        if (v) begin
            smp.push_back(s);
            n_acc++;
            if (n_acc == FL || (n_acc > FL && (n_acc - FL) % HP == 0)) begin
                queued = 1'b0;
                last_end = -1;
                foreach (starts[i]) if (starts[i] > cyc) queued = 1'b1;
                if (starts.size() > 0) last_end = starts[starts.size()-1] + FL - 1;
                if (queued) begin
                    dropped = 1'b1;
                end else begin
                    st = (last_end + 1 > cyc + 1) ? last_end + 1 : cyc + 1;
                    starts.push_back(st);
                    for (int k = 0; k < FL; k++) begin
                        exp_data[st+1+k] = wfloor(smp[n_acc-FL+k], coef_m[k]);
                        exp_fs[st+1+k]   = (k == 0);
                    end
                end
            end
        end
        if (dropped) ov_m = 1'b1;
        else if (clr) ov_m = 1'b0;
        if (we) coef_m[addr] = data;
        #1;
        exp_v  = exp_data.exists(cyc);
        exp_f  = 1'b0;
        exp_d8 = '0;
        if (exp_v) begin
            exp_f  = exp_fs[cyc];
            exp_d8 = W'(exp_data[cyc]);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (data_out !== '0) begin n_fail++; $display("FAIL reset_data_out: got %0d, expected 0", data_out); end
        n_checks++;
        if (data_valid !== 1'b0) begin n_fail++; $display("FAIL reset_data_valid: got %b, expected 0", data_valid); end
        n_checks++;
        if (frame_start !== 1'b0) begin n_fail++; $display("FAIL reset_frame_start: got %b, expected 0", frame_start); end
        n_checks++;
        if (overrun !== 1'b0) begin n_fail++; $display("FAIL reset_overrun: got %b, expected 0", overrun); end
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_ramp;
        int ref_a[8] = '{0, 0, 1, 2, 3, 4, 5, 6};
        int t7;
        int first_v;
        first_v = -1;
        obs.delete();
        for (int i = 0; i < FL; i++) tick(1'b0, 0, 1'b0, 1'b1, i, 255);
        for (int i = 0; i < FL + 14; i++) begin
            if (i < FL) tick(1'b1, i, 1'b0, 1'b0, 0, 0);
            else        tick(1'b0, 0, 1'b0, 1'b0, 0, 0);
            if (i == FL - 1) t7 = cyc;
            n_checks++;
            if (data_valid !== exp_v || frame_start !== exp_f || overrun !== ov_m || (exp_v && data_out !== exp_d8)) begin
                n_fail++;
                $display("FAIL ramp_stream cyc=%0d: got valid=%b fs=%b data=%0d ovr=%b, expected valid=%b fs=%b data=%0d ovr=%b",
                         cyc, data_valid, frame_start, $signed(data_out), overrun, exp_v, exp_f, $signed(exp_d8), ov_m);
            end
            if (data_valid === 1'b1) begin
                if (first_v < 0) first_v = cyc;
                obs.push_back($signed(data_out));
            end
        end
        n_checks++;
        if (obs.size() != 8) begin n_fail++; $display("FAIL ramp_count: got %0d valid cycles, expected 8", obs.size()); end
        n_checks++;
        if (first_v != t7 + 2) begin n_fail++; $display("FAIL ramp_latency: got first valid at %0d, expected %0d", first_v, t7 + 2); end
        for (int i = 0; i < 8 && i < obs.size(); i++) begin
            n_checks++;
            if (obs[i] != ref_a[i]) begin n_fail++; $display("FAIL ramp_value[%0d]: got %0d, expected %0d", i, obs[i], ref_a[i]); end
        end
    endtask

    task automatic test_slow;
        int ref_b[8] = '{3, 4, 5, 6, 7, 8, 9, 10};
        obs.delete();
        for (int i = 0; i < 4 * 3 + 12; i++) begin
            if (i < 12 && i % 3 == 0) tick(1'b1, 8 + i / 3, 1'b0, 1'b0, 0, 0);
            else                      tick(1'b0, 0, 1'b0, 1'b0, 0, 0);
            n_checks++;
            if (data_valid !== exp_v || frame_start !== exp_f || overrun !== ov_m || (exp_v && data_out !== exp_d8)) begin
                n_fail++;
                $display("FAIL slow_stream cyc=%0d: got valid=%b fs=%b data=%0d ovr=%b, expected valid=%b fs=%b data=%0d ovr=%b",
                         cyc, data_valid, frame_start, $signed(data_out), overrun, exp_v, exp_f, $signed(exp_d8), ov_m);
            end
            if (data_valid === 1'b1) obs.push_back($signed(data_out));
        end
        n_checks++;
        if (obs.size() != 8) begin n_fail++; $display("FAIL slow_count: got %0d valid cycles, expected 8", obs.size()); end
        for (int i = 0; i < 8 && i < obs.size(); i++) begin
            n_checks++;
            if (obs[i] != ref_b[i]) begin n_fail++; $display("FAIL slow_value[%0d]: got %0d, expected %0d", i, obs[i], ref_b[i]); end
        end
    endtask

    task automatic test_coef_ramp;
        int s;
        do_reset();
        obs.delete();
        for (int i = 0; i < FL; i++) tick(1'b0, 0, 1'b0, 1'b1, i, 32 * i);
        for (int i = 0; i < 12 + 16; i++) begin
            if (i == 7)       tick(1'b1, -128, 1'b0, 1'b0, 0, 0);
            else if (i == 11) tick(1'b1, -1, 1'b0, 1'b0, 0, 0);
            else if (i < 12) begin
                s = $urandom_range(0, 255) - 128;
                tick(1'b1, s, 1'b0, 1'b0, 0, 0);
            end else tick(1'b0, 0, 1'b0, 1'b0, 0, 0);
            n_checks++;
            if (data_valid !== exp_v || frame_start !== exp_f || overrun !== ov_m || (exp_v && data_out !== exp_d8)) begin
                n_fail++;
                $display("FAIL coef_stream cyc=%0d: got valid=%b fs=%b data=%0d ovr=%b, expected valid=%b fs=%b data=%0d ovr=%b",
                         cyc, data_valid, frame_start, $signed(data_out), overrun, exp_v, exp_f, $signed(exp_d8), ov_m);
            end
            if (data_valid === 1'b1) obs.push_back($signed(data_out));
        end
        n_checks++;
        if (obs.size() != 16) begin
            n_fail++; $display("FAIL coef_count: got %0d valid cycles, expected 16", obs.size());
        end else begin
            n_checks++;
            if (obs[7] != -112) begin n_fail++; $display("FAIL coef_neg128: got %0d, expected -112", obs[7]); end
            n_checks++;
            if (obs[15] != -1) begin n_fail++; $display("FAIL coef_neg1: got %0d, expected -1", obs[15]); end
        end
    endtask

    task automatic test_back_to_back;
        int run;
        int maxrun;
        int fs_cnt;
        run = 0; maxrun = 0; fs_cnt = 0;
        do_reset();
        for (int i = 0; i < FL; i++) tick(1'b0, 0, 1'b0, 1'b1, i, $urandom_range(0, 255));
        for (int i = 0; i < 24 + 14; i++) begin
            if (i < 24) tick(1'b1, $urandom_range(0, 255) - 128, 1'b0, 1'b0, 0, 0);
            else        tick(1'b0, 0, 1'b0, 1'b0, 0, 0);
            n_checks++;
            if (data_valid !== exp_v || frame_start !== exp_f || overrun !== ov_m || (exp_v && data_out !== exp_d8)) begin
                n_fail++;
                $display("FAIL b2b_stream cyc=%0d: got valid=%b fs=%b data=%0d ovr=%b, expected valid=%b fs=%b data=%0d ovr=%b",
                         cyc, data_valid, frame_start, $signed(data_out), overrun, exp_v, exp_f, $signed(exp_d8), ov_m);
            end
            if (i == 14) begin
                n_checks++;
                if (overrun !== 1'b0) begin n_fail++; $display("FAIL b2b_no_early_overrun: got %b, expected 0", overrun); end
            end
            if (data_valid === 1'b1) begin run++; if (run > maxrun) maxrun = run; end
            else run = 0;
            if (frame_start === 1'b1) fs_cnt++;
        end
        n_checks++;
        if (maxrun != 24) begin n_fail++; $display("FAIL b2b_gapless: got run of %0d, expected 24", maxrun); end
        n_checks++;
        if (fs_cnt != 3) begin n_fail++; $display("FAIL b2b_frames: got %0d frame starts, expected 3", fs_cnt); end
        n_checks++;
        if (overrun !== 1'b1) begin n_fail++; $display("FAIL b2b_overrun_set: got %b, expected 1", overrun); end
        tick(1'b0, 0, 1'b1, 1'b0, 0, 0);
        n_checks++;
        if (overrun !== 1'b0 || ov_m !== 1'b0) begin n_fail++; $display("FAIL b2b_overrun_clr: got %b, expected 0", overrun); end
    endtask

    task automatic test_reset_mid_burst;
        int vcnt;
        for (int i = 0; i < FL; i++) tick(1'b0, 0, 1'b0, 1'b1, i, 255);
        do_reset();
        for (int i = 0; i < FL + 5; i++) begin
            if (i < FL) tick(1'b1, $urandom_range(0, 255) - 128, 1'b0, 1'b0, 0, 0);
            else        tick(1'b0, 0, 1'b0, 1'b0, 0, 0);
            n_checks++;
            if (data_valid !== exp_v || frame_start !== exp_f || overrun !== ov_m || (exp_v && data_out !== exp_d8)) begin
                n_fail++;
                $display("FAIL midrst_stream cyc=%0d: got valid=%b fs=%b data=%0d ovr=%b, expected valid=%b fs=%b data=%0d ovr=%b",
                         cyc, data_valid, frame_start, $signed(data_out), overrun, exp_v, exp_f, $signed(exp_d8), ov_m);
            end
        end
        n_checks++;
        if (data_valid !== 1'b1) begin n_fail++; $display("FAIL midrst_in_burst: got valid=%b, expected 1", data_valid); end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (data_valid !== 1'b0 || data_out !== '0 || frame_start !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_async: got valid=%b data=%0d fs=%b, expected valid=0 data=0 fs=0", data_valid, data_out, frame_start);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        vcnt = 0;
        for (int i = 0; i < 2 * FL + 12; i++) begin
            if (i < FL - 1 || i == FL + 6) tick(1'b1, $urandom_range(0, 255) - 128, 1'b0, 1'b0, 0, 0);
            else                           tick(1'b0, 0, 1'b0, 1'b0, 0, 0);
            n_checks++;
            if (data_valid !== exp_v || frame_start !== exp_f || overrun !== ov_m || (exp_v && data_out !== exp_d8)) begin
                n_fail++;
                $display("FAIL midrst_restart cyc=%0d: got valid=%b fs=%b data=%0d ovr=%b, expected valid=%b fs=%b data=%0d ovr=%b",
                         cyc, data_valid, frame_start, $signed(data_out), overrun, exp_v, exp_f, $signed(exp_d8), ov_m);
            end
            if (i < FL + 6) begin
                n_checks++;
                if (data_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_early_burst cyc=%0d: got valid=%b, expected 0", cyc, data_valid); end
            end
            if (data_valid === 1'b1) vcnt++;
        end
        n_checks++;
        if (vcnt != 8) begin n_fail++; $display("FAIL midrst_burst_len: got %0d, expected 8", vcnt); end
    endtask

    task automatic test_random;
        do_reset();
        for (int i = 0; i < FL; i++) tick(1'b0, 0, 1'b0, 1'b1, i, $urandom_range(0, 255));
        for (int i = 0; i < 300; i++) begin
            tick($urandom_range(0, 2) != 0, $urandom_range(0, 255) - 128, $urandom_range(0, 15) == 0, 1'b0, 0, 0);
            n_checks++;
            if (data_valid !== exp_v || frame_start !== exp_f || overrun !== ov_m || (exp_v && data_out !== exp_d8)) begin
                n_fail++;
                $display("FAIL random_stream cyc=%0d: got valid=%b fs=%b data=%0d ovr=%b, expected valid=%b fs=%b data=%0d ovr=%b",
                         cyc, data_valid, frame_start, $signed(data_out), overrun, exp_v, exp_f, $signed(exp_d8), ov_m);
            end
        end
    endtask

    initial begin
        test_reset();
        test_ramp();
        test_slow();
        test_coef_ramp();
        test_back_to_back();
        test_reset_mid_burst();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
